// File: rtl/alu_ctrl_pkg.sv
// ============================================================================
//  Module      : alu_ctrl_pkg
//  Description : Shared types and constants for the register-to-register ALU
//                instruction sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_ctrl_pkg;

   localparam int PW_DEFAULT = 6;

   localparam logic [2:0] REG_R0 = 3'd0;
   localparam logic [2:0] REG_R1 = 3'd1;
   localparam logic [2:0] REG_R2 = 3'd2;
   localparam logic [2:0] REG_R3 = 3'd3;
   localparam logic [2:0] REG_P0 = 3'd4;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_FETCH_A = 3'd1,
      ST_FETCH_B = 3'd2,
      ST_EXEC    = 3'd3,
      ST_WRITE   = 3'd4,
      ST_DONE    = 3'd5
   } state_t;

endpackage

`default_nettype wire

// File: rtl/reg_sel_decode.sv
// ============================================================================
//  Module      : reg_sel_decode
//  Description : Maps a 3-bit register select plus enable to one-hot strobes
//                strb[0..3] = R0..R3, strb[4] = P0. Codes 5..7 decode to none.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_sel_decode
   import alu_ctrl_pkg::*;
(
   input  logic [2:0] sel,
   input  logic       en,
   output logic [4:0] strb
);

   always_comb begin
      strb = '0;
      if (en) begin
         case (sel)
            REG_R0:  strb[0] = 1'b1;
            REG_R1:  strb[1] = 1'b1;
            REG_R2:  strb[2] = 1'b1;
            REG_R3:  strb[3] = 1'b1;
            REG_P0:  strb[4] = 1'b1;
            default: strb    = '0;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: rtl/rb_alu_op_fsm.sv
// ============================================================================
//  Module      : rb_alu_op_fsm
//  Description : Moore sequencer for Ri <- Ri op Rj. Optional macro
//                ALUOP_LIVE_PARAMS_EN decodes live selects instead of captured.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rb_alu_op_fsm
   import alu_ctrl_pkg::*;
#(
   parameter int PW = PW_DEFAULT
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          done_fetch,
   input  logic          start,
   input  logic [PW-1:0] parameter1,
   input  logic [PW-1:0] parameter2,
   output logic          r0in,
   output logic          r1in,
   output logic          r2in,
   output logic          r3in,
   output logic          P0in,
   output logic          R0OutEn,
   output logic          R1OutEn,
   output logic          R2OutEn,
   output logic          R3OutEn,
   output logic          P0OutEn,
   output logic          ALUinR1,
   output logic          ALUinR2,
   output logic          enregalu,
   output logic          ALUoutEn,
   output logic          Regiout,
   output logic          Regjout,
   output logic          Regiin,
   output logic          done
);

   state_t     r_state;
   state_t     w_next;
   logic [2:0] w_sel_i;
   logic [2:0] w_sel_j;
   logic [4:0] w_oe_i;
   logic [4:0] w_oe_j;
   logic [4:0] w_ld_i;
   logic [4:0] w_oe;
   logic       w_accept;
   logic       w_unused_hi;

   assign w_accept    = (r_state == ST_IDLE) && start && done_fetch;
   // Only the low three bits of each select field are meaningful.
   assign w_unused_hi = ^{parameter1[PW-1:3], parameter2[PW-1:3]};

`ifdef ALUOP_LIVE_PARAMS_EN
   assign w_sel_i = parameter1[2:0];
   assign w_sel_j = parameter2[2:0];
`else
   logic [2:0] r_sel_i;
   logic [2:0] r_sel_j;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_sel_i <= '0;
         r_sel_j <= '0;
      end else if (w_accept) begin
         r_sel_i <= parameter1[2:0];
         r_sel_j <= parameter2[2:0];
      end
   end

   assign w_sel_i = r_sel_i;
   assign w_sel_j = r_sel_j;
`endif

   always_ff @(posedge clk) begin
      if (!rst) r_state <= ST_IDLE;
      else      r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:    if (w_accept) w_next = ST_FETCH_A;
         ST_FETCH_A: w_next = ST_FETCH_B;
         ST_FETCH_B: w_next = ST_EXEC;
         ST_EXEC:    w_next = ST_WRITE;
         ST_WRITE:   w_next = ST_DONE;
         ST_DONE:    w_next = ST_IDLE;
         default:    w_next = ST_IDLE;
      endcase
   end

   reg_sel_decode u_oe_i (
      .sel  (w_sel_i),
      .en   (r_state == ST_FETCH_A),
      .strb (w_oe_i)
   );

   reg_sel_decode u_oe_j (
      .sel  (w_sel_j),
      .en   (r_state == ST_FETCH_B),
      .strb (w_oe_j)
   );

   reg_sel_decode u_ld_i (
      .sel  (w_sel_i),
      .en   (r_state == ST_WRITE),
      .strb (w_ld_i)
   );

   // The two OutEn decoders are enabled in mutually exclusive states.
   assign w_oe = w_oe_i | w_oe_j;

   assign R0OutEn = w_oe[0];
   assign R1OutEn = w_oe[1];
   assign R2OutEn = w_oe[2];
   assign R3OutEn = w_oe[3];
   assign P0OutEn = w_oe[4];

   assign r0in = w_ld_i[0];
   assign r1in = w_ld_i[1];
   assign r2in = w_ld_i[2];
   assign r3in = w_ld_i[3];
   assign P0in = w_ld_i[4];

   always_comb begin
      ALUinR1  = 1'b0;
      ALUinR2  = 1'b0;
      enregalu = 1'b0;
      ALUoutEn = 1'b0;
      Regiout  = 1'b0;
      Regjout  = 1'b0;
      Regiin   = 1'b0;
      done     = 1'b0;
      case (r_state)
         ST_FETCH_A: begin
            Regiout = 1'b1;
            ALUinR1 = 1'b1;
         end
         ST_FETCH_B: begin
            Regjout = 1'b1;
            ALUinR2 = 1'b1;
         end
         ST_EXEC:  enregalu = 1'b1;
         ST_WRITE: begin
            ALUoutEn = 1'b1;
            Regiin   = 1'b1;
         end
         ST_DONE:  done = 1'b1;
         default:  done = 1'b0;
      endcase
   end

endmodule

`default_nettype wire

// File: tb/tb_rb_alu_op_fsm.sv
// ============================================================================
//  Module      : tb_rb_alu_op_fsm
//  Description : Self-checking bench for rb_alu_op_fsm against a step-count
//                reference model; directed cases followed by random traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rb_alu_op_fsm;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       done_fetch = 1'b0;
   logic       start = 1'b0;
   logic [5:0] parameter1 = '0;
   logic [5:0] parameter2 = '0;
   logic r0in, r1in, r2in, r3in, P0in;
   logic R0OutEn, R1OutEn, R2OutEn, R3OutEn, P0OutEn;
   logic ALUinR1, ALUinR2, enregalu, ALUoutEn, Regiout, Regjout, Regiin, done;

   int errors = 0;
   int checks = 0;

   // Reference model: position within the instruction (0 = idle, 1..5 = cycle
   // of the instruction) plus the select codes latched at acceptance.
   int       m_step = 0;
   int       m_i = 0;
   int       m_j = 0;

   always #5 clk = ~clk;

   rb_alu_op_fsm #(.PW(6)) dut (
      .clk        (clk),
      .rst        (rst),
      .done_fetch (done_fetch),
      .start      (start),
      .parameter1 (parameter1),
      .parameter2 (parameter2),
      .r0in       (r0in),
      .r1in       (r1in),
      .r2in       (r2in),
      .r3in       (r3in),
      .P0in       (P0in),
      .R0OutEn    (R0OutEn),
      .R1OutEn    (R1OutEn),
      .R2OutEn    (R2OutEn),
      .R3OutEn    (R3OutEn),
      .P0OutEn    (P0OutEn),
      .ALUinR1    (ALUinR1),
      .ALUinR2    (ALUinR2),
      .enregalu   (enregalu),
      .ALUoutEn   (ALUoutEn),
      .Regiout    (Regiout),
      .Regjout    (Regjout),
      .Regiin     (Regiin),
      .done       (done)
   );

   // Observed vector: {r0..r3,P0 in | R0..R3,P0 OutEn | A1,A2,enr,aoe,Ri,Rj,Rii,done}
   function automatic logic [17:0] obs_vec();
      return {r0in, r1in, r2in, r3in, P0in,
              R0OutEn, R1OutEn, R2OutEn, R3OutEn, P0OutEn,
              ALUinR1, ALUinR2, enregalu, ALUoutEn, Regiout, Regjout, Regiin, done};
   endfunction

   // Register k (0..4) lights bit 4-k of a {R0,R1,R2,R3,P0} group; 5..7 light none.
   function automatic logic [4:0] reg_bit(input int sel);
      if (sel < 5) return 5'(16 >> sel);
      return 5'b0;
   endfunction

   function automatic logic [17:0] exp_vec(input int stp, input int si, input int sj);
      logic [4:0] ld;
      logic [4:0] oe;
      logic [7:0] ctl;
      ld = 5'b0; oe = 5'b0; ctl = 8'b0;
      case (stp)
         1: begin oe = reg_bit(si); ctl = 8'b1000_1000; end
         2: begin oe = reg_bit(sj); ctl = 8'b0100_0100; end
         3: ctl = 8'b0010_0000;
         4: begin ld = reg_bit(si); ctl = 8'b0001_0010; end
         5: ctl = 8'b0000_0001;
         default: ctl = 8'b0;
      endcase
      return {ld, oe, ctl};
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, want, $time);
      end
   endtask

   // Drive one cycle of inputs (called just after a falling edge), advance the
   // model across the rising edge, then compare at the next falling edge.
   task automatic cyc(input string tag, input logic r, input logic s, input logic df,
                      input logic [5:0] p1, input logic [5:0] p2);
      rst = r; start = s; done_fetch = df; parameter1 = p1; parameter2 = p2;
      @(posedge clk);
      if (!r) begin
         m_step = 0; m_i = 0; m_j = 0;
      end else if (m_step == 0) begin
         if (s && df) begin
            m_step = 1; m_i = int'(p1[2:0]); m_j = int'(p2[2:0]);
         end
      end else begin
         m_step = (m_step == 5) ? 0 : m_step + 1;
      end
      @(negedge clk);
      chk(tag, 32'(obs_vec()), 32'(exp_vec(m_step, m_i, m_j)));
   endtask

   initial begin
      @(negedge clk);
      // Reset held with start asserted, then released with start low.
      cyc("reset0", 1'b0, 1'b1, 1'b1, 6'd1, 6'd2);
      cyc("reset1", 1'b0, 1'b1, 1'b1, 6'd1, 6'd2);
      for (int k = 0; k < 3; k++) cyc("idle", 1'b1, 1'b0, 1'b1, 6'd0, 6'd0);

      // Basic op R0 <- R0 op R3, then an explicit done/pulse check.
      cyc("basic_fa", 1'b1, 1'b1, 1'b1, 6'b000000, 6'b000011);
      chk("basic_r0oe", 32'(R0OutEn), 32'd1);
      cyc("basic_fb", 1'b1, 1'b0, 1'b0, 6'd0, 6'd3);
      chk("basic_r3oe", 32'(R3OutEn), 32'd1);
      cyc("basic_ex", 1'b1, 1'b0, 1'b0, 6'd0, 6'd3);
      cyc("basic_wr", 1'b1, 1'b0, 1'b0, 6'd0, 6'd3);
      chk("basic_r0in", 32'(r0in), 32'd1);
      cyc("basic_dn", 1'b1, 1'b0, 1'b0, 6'd0, 6'd3);
      chk("basic_done", 32'(done), 32'd1);
      cyc("basic_idle", 1'b1, 1'b0, 1'b0, 6'd0, 6'd3);
      chk("basic_done_off", 32'(done), 32'd0);

      // Handshake: start without done_fetch stays idle.
      for (int k = 0; k < 5; k++) cyc("hs_wait", 1'b1, 1'b1, 1'b0, 6'd1, 6'd2);
      cyc("hs_go", 1'b1, 1'b1, 1'b1, 6'd1, 6'd2);
      chk("hs_go_fa", 32'(Regiout), 32'd1);
      for (int k = 0; k < 4; k++) cyc("hs_run", 1'b1, 1'b0, 1'b0, 6'd1, 6'd2);
      cyc("hs_idle", 1'b1, 1'b0, 1'b0, 6'd1, 6'd2);

      // P0 used as both operands.
      cyc("p0_fa", 1'b1, 1'b1, 1'b1, 6'd4, 6'd4);
      chk("p0_fa_oe", 32'(P0OutEn), 32'd1);
      for (int k = 0; k < 5; k++) cyc("p0_run", 1'b1, 1'b0, 1'b0, 6'd4, 6'd4);

      // Upper select bits ignored: 6'b111010 is R2.
      cyc("hi_fa", 1'b1, 1'b1, 1'b1, 6'b111010, 6'b101001);
      chk("hi_r2oe", 32'(R2OutEn), 32'd1);
      for (int k = 0; k < 5; k++) cyc("hi_run", 1'b1, 1'b0, 1'b0, 6'b111010, 6'b101001);

      // Invalid select: strobes follow state, no per-register enables.
      cyc("inv_fa", 1'b1, 1'b1, 1'b1, 6'd6, 6'd7);
      for (int k = 0; k < 5; k++) cyc("inv_run", 1'b1, 1'b0, 1'b0, 6'd6, 6'd7);

      // Mid-op reset during EXEC, then a full fresh sequence.
      cyc("mr_fa", 1'b1, 1'b1, 1'b1, 6'd2, 6'd1);
      cyc("mr_fb", 1'b1, 1'b0, 1'b0, 6'd2, 6'd1);
      cyc("mr_ex", 1'b1, 1'b0, 1'b0, 6'd2, 6'd1);
      cyc("mr_rst", 1'b0, 1'b0, 1'b0, 6'd2, 6'd1);
      chk("mr_rst_zero", 32'(obs_vec()), 32'd0);
      cyc("mr_after", 1'b1, 1'b0, 1'b0, 6'd2, 6'd1);
      chk("mr_no_done", 32'(done), 32'd0);
      for (int k = 0; k < 6; k++) cyc("mr_new", 1'b1, (k == 0), 1'b1, 6'd3, 6'd0);

      // Parameter change during FETCH_B must not affect the destination.
      cyc("ps_fa", 1'b1, 1'b1, 1'b1, 6'd1, 6'd0);
      cyc("ps_fb", 1'b1, 1'b0, 1'b0, 6'd2, 6'd0);
      cyc("ps_ex", 1'b1, 1'b0, 1'b0, 6'd2, 6'd0);
      cyc("ps_wr", 1'b1, 1'b0, 1'b0, 6'd2, 6'd0);
      chk("ps_r1in", 32'(r1in), 32'd1);
      chk("ps_r2in", 32'(r2in), 32'd0);
      cyc("ps_dn", 1'b1, 1'b0, 1'b0, 6'd2, 6'd0);

      // Back-to-back: start held high with done_fetch.
      for (int k = 0; k < 12; k++) cyc("b2b", 1'b1, 1'b1, 1'b1, 6'd3, 6'd4);

      // Random traffic including occasional resets.
      for (int k = 0; k < 400; k++) begin
         cyc("rand", ($urandom_range(0, 19) != 0), $urandom_range(0, 1) == 1,
             $urandom_range(0, 9) < 7, 6'($urandom), 6'($urandom));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
